// File: rtl/period_meter.sv
// Measures the period of an asynchronous input in clock cycles, from one synchronized
// rising edge to the next, and offers each result on a valid/ready output.
module period_meter #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             enable,
    output logic [WIDTH-1:0] period,
    output logic             overflow,
    output logic             valid,
    input  logic             ready,
    output logic             lost
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   synced;
    logic                   rise;
    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       count_q, count_d;
    logic                   result_evt;

    assign synced = sync_q[SYNC_STAGES-1];
    assign rise   = synced & ~hist_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            hist_q <= synced;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Dropping enable wins over everything, including a rise in the same cycle.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        result_evt = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    count_d = '0;
                    state_d = ARM;
                end
                ARM: begin
                    count_d = '0;
                    if (rise) begin
                        state_d = COUNT;
                        count_d = CNT_ONE;
                    end
                end
                COUNT: begin
                    if (rise) begin
                        result_evt = 1'b1;
                        count_d    = CNT_ONE;
                    end else if (count_q != CNT_MAX) begin
                        count_d = count_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // Handshake: a result is transferred on any edge where valid=1 and ready=1; while
    // valid=1 the period/overflow pair is frozen, and a result completing while the held
    // one cannot leave is dropped and recorded in the sticky lost flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            period   <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
            lost     <= 1'b0;
        end else if (result_evt) begin
            if (!valid || ready) begin
                period   <= count_q;
                overflow <= (count_q == CNT_MAX);
                valid    <= 1'b1;
            end else begin
                lost <= 1'b1;
            end
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: square-wave vector table plus corner sequences for
// saturation, dropped results, enable removal and reset during a held result.
module tb_period_meter;

    localparam int W = 16;

    logic         clock;
    logic         reset;
    logic         sig_in;
    logic         enable;
    logic [W-1:0] period;
    logic         overflow;
    logic         valid;
    logic         ready;
    logic         lost;

    int checks = 0;
    int errors = 0;
    int accepted = 0;

    logic [W:0] exp_q[$];

    typedef struct {
        int           hi;
        int           lo;
        int           nper;
        logic [W-1:0] exp_period;
    } vec_t;

    vec_t vecs[5];

    period_meter #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .sig_in   (sig_in),
        .enable   (enable),
        .period   (period),
        .overflow (overflow),
        .valid    (valid),
        .ready    (ready),
        .lost     (lost)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive sig_in for one cycle; any result accepted at the coming edge is scored.
    task automatic drive(input logic s);
        logic [W:0] e;
        sig_in = s;
        if (valid && ready) begin
            accepted++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got period=%0d overflow=%0b, required no result",
                         period, overflow);
            end else begin
                e = exp_q.pop_front();
                check("result_period", 32'(period), 32'(e[W-1:0]));
                check("result_overflow", 32'(overflow), 32'(e[W]));
            end
        end
        tick();
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        repeat (n) begin
            repeat (hi) drive(1'b1);
            repeat (lo) drive(1'b0);
        end
    endtask

    task automatic start(input logic rdy);
        reset  = 1'b0;
        sig_in = 1'b0;
        enable = 1'b0;
        ready  = rdy;
        repeat (3) tick();
        reset  = 1'b1;
        enable = 1'b1;
        repeat (4) drive(1'b0);
    endtask

    task automatic check_drained(input string name);
        repeat (8) drive(1'b0);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{hi: 5, lo: 5, nper: 6, exp_period: 16'd10};
        vecs[1] = '{hi: 1, lo: 1, nper: 8, exp_period: 16'd2};
        vecs[2] = '{hi: 3, lo: 4, nper: 5, exp_period: 16'd7};
        vecs[3] = '{hi: 2, lo: 1, nper: 6, exp_period: 16'd3};
        vecs[4] = '{hi: 9, lo: 8, nper: 4, exp_period: 16'd17};

        // reset held with sig_in toggling
        reset  = 1'b0;
        enable = 1'b1;
        ready  = 1'b1;
        sig_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sig_in = ~sig_in;
            tick();
            check("rst_period", 32'(period), 32'd0);
            check("rst_overflow", 32'(overflow), 32'd0);
            check("rst_valid", 32'(valid), 32'd0);
            check("rst_lost", 32'(lost), 32'd0);
        end
        reset = 1'b1;
        tick();
        check("rel_period", 32'(period), 32'd0);
        check("rel_valid", 32'(valid), 32'd0);
        check("rel_lost", 32'(lost), 32'd0);

        // square-wave table, ready held high
        for (int v = 0; v < 5; v++) begin
            start(1'b1);
            accepted = 0;
            for (int k = 0; k < vecs[v].nper - 1; k++)
                exp_q.push_back({1'b0, vecs[v].exp_period});
            wave(vecs[v].hi, vecs[v].lo, vecs[v].nper);
            check_drained("vec_pending");
            check("vec_valid_cycles", 32'(accepted), 32'(vecs[v].nper - 1));
            check("vec_lost", 32'(lost), 32'd0);
        end

        // saturation then a normal period
        start(1'b1);
        exp_q.push_back({1'b1, 16'hFFFF});
        exp_q.push_back({1'b0, 16'd10});
        drive(1'b1);
        repeat (4) drive(1'b1);
        repeat (70000) drive(1'b0);
        wave(5, 5, 2);
        check_drained("ovf_pending");

        // held result, second result dropped
        start(1'b0);
        wave(5, 5, 3);
        repeat (4) drive(1'b0);
        check("lost_period", 32'(period), 32'd10);
        check("lost_overflow", 32'(overflow), 32'd0);
        check("lost_valid", 32'(valid), 32'd1);
        check("lost_flag", 32'(lost), 32'd1);
        ready = 1'b1;
        exp_q.push_back({1'b0, 16'd10});
        drive(1'b0);
        check("lost_valid_cleared", 32'(valid), 32'd0);
        check("lost_sticky", 32'(lost), 32'd1);
        check_drained("lost_pending");

        // enable removed mid-count, then re-armed
        start(1'b1);
        exp_q.push_back({1'b0, 16'd10});
        wave(5, 5, 2);
        repeat (3) drive(1'b0);
        enable = 1'b0;
        drive(1'b0);
        drive(1'b1);
        drive(1'b1);
        repeat (3) drive(1'b0);
        enable = 1'b1;
        repeat (4) drive(1'b0);
        exp_q.push_back({1'b0, 16'd10});
        wave(5, 5, 2);
        check_drained("en_pending");

        // reset while a result is held and counting continues
        start(1'b0);
        wave(5, 5, 2);
        repeat (3) drive(1'b0);
        check("hold_valid", 32'(valid), 32'd1);
        check("hold_period", 32'(period), 32'd10);
        reset = 1'b0;
        tick();
        check("midrst_period", 32'(period), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_lost", 32'(lost), 32'd0);
        reset = 1'b1;
        ready = 1'b1;
        repeat (5) drive(1'b0);
        check("postrst_valid", 32'(valid), 32'd0);
        check_drained("postrst_pending");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter: WIDTH, 16, width of period counter and result.
REQ-002 Parameter: SYNC_STAGES, 2, synchronizer flops on sig_in (minimum 2).
REQ-003 The block SHALL use one clock and a synchronous, active-low reset; no other clock or asynchronous reset.
REQ-004 Port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  synchronous active-low reset; 0 = reset.
REQ-006 Port: sig_in  input  1  signal to measure (e.g. divided clock); asynchronous to clock.
REQ-007 Port: enable  input  1  1 = measure; 0 = idle.
REQ-008 Port: period  output  WIDTH  last accepted measurement, in clock cycles.
REQ-009 Port: overflow  output  1  qualifies period: measurement saturated.
REQ-010 Port: valid  output  1  period/overflow hold an unconsumed result.
REQ-011 Port: ready  input  1  consumer accepts the result when valid=1 and ready=1.
REQ-012 Port: lost  output  1  sticky: a completed measurement was dropped.

Function
REQ-013 sig_in SHALL pass through SYNC_STAGES flops, then one history flop; rise = synced 1 and history 0, a one-cycle internal pulse.
REQ-014 A sig_in 0->1 transition meeting setup before edge k SHALL produce rise in the cycle after edge k+SYNC_STAGES-1 (fixed latency).
REQ-015 FSM states: IDLE, ARM, COUNT; encoding free.
REQ-016 IDLE: counter=0; enable=1 -> ARM next cycle.
REQ-017 ARM: counter held 0; rise -> COUNT, counter<=1; no result produced.
REQ-018 COUNT, no rise: counter<=counter+1, saturating at 2^WIDTH-1 (never wraps).
REQ-019 COUNT, rise: result event; counter<=1; stay in COUNT.
REQ-020 Result event: period<=counter, overflow<=(counter==2^WIDTH-1), valid<=1; sig_in period of P cycles yields period=P.
REQ-021 enable=0 in any state SHALL force IDLE and counter=0 next cycle; a rise in that cycle is ignored; a held result (valid=1) is kept.
REQ-022 valid SHALL stay 1, period/overflow stable, until a cycle with ready=1; then valid<=0 unless a result event occurs in that cycle.
REQ-023 Result event with valid=1 and ready=0: new result discarded, held result unchanged, lost<=1.
REQ-024 Result event with valid=1 and ready=1 (same cycle): new result loaded, valid stays 1, lost unchanged.
REQ-025 lost SHALL be cleared only by reset.
REQ-026 ready while valid=0 SHALL have no effect.

Reset
REQ-027 reset=0 at a clock edge SHALL set: state IDLE, counter 0, synchronizer/history flops 0, period 0, overflow 0, valid 0, lost 0.
REQ-028 Reset SHALL override all other inputs, including mid-measurement and with valid=1; first rise after reset release is treated as a fresh edge only if synced sig_in returns from 0.

Verification
REQ-029 reset=0 3 cycles, sig_in toggling -> period=0, overflow=0, valid=0, lost=0 throughout and on first cycle after release.
REQ-030 WIDTH=16, enable=1, ready=1, sig_in square wave period 10 cycles -> first valid at second detected rise, period=10, overflow=0, valid pulses 1 cycle every 10 cycles.
REQ-031 sig_in driven by divide-by-two of clock (toggles every cycle), ready=1 -> every result period=2, overflow=0.
REQ-032 WIDTH=16, one rise, sig_in low 70000 cycles, then rise -> period=65535, overflow=1, valid=1; next 10-cycle period -> period=10, overflow=0.
REQ-033 ready=0, period-10 stimulus, two results complete -> period=10 held, valid=1, lost=1; ready=1 one cycle with no result event -> valid=0, lost stays 1.
REQ-034 enable 1->0 mid-COUNT, re-asserted -> no result until two new rises after re-enable; reset=0 with valid=1 mid-count -> all outputs 0 next edge.
